// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared single-precision definitions for the truncating fp datapath blocks
// (fp_add, fp_sub_pipe, future fp_mul): field widths, special encodings, the
// unpacked-operand struct, the fp_sub_pipe stage-register structs and an
// unpack helper that flushes denormals to zero.
// ----------------------------------------------------------------------------
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int DW    = EXP_W + MAN_W + 1;
    localparam int BIAS  = 127;
    localparam int SIG_W = MAN_W + 1;    // significand with hidden bit
    localparam int SUM_W = SIG_W + 1;    // one carry bit above the significand

    localparam logic [DW-1:0]    FP_POS_ZERO = 32'h0000_0000;
    localparam logic [DW-1:0]    FP_QNAN     = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] FP_INF_EXP  = 8'hFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] mant;
        logic             is_zero;
    } fp_unpacked_t;

    // S1 -> S2: operands already ordered so that X has the larger magnitude.
    typedef struct packed {
        logic             valid;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] mant_x;
        logic [SIG_W-1:0] mant_y;
        logic [EXP_W-1:0] diff;
        logic             eff_sub;
        logic             special;
        logic [DW-1:0]    special_val;
    } s1_reg_t;

    // S2 -> S3: raw magnitude sum, not yet normalized.
    typedef struct packed {
        logic             valid;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SUM_W-1:0] sum;
        logic             special;
        logic [DW-1:0]    special_val;
    } s2_reg_t;

    // negate flips the sign so a subtrahend can be treated as an addend.
    function automatic fp_unpacked_t fp_unpack(input logic [DW-1:0] f, input logic negate);
        fp_unpacked_t u;
        u.sign    = f[DW-1] ^ negate;
        u.exp     = f[DW-2:MAN_W];
        u.is_zero = (u.exp == '0);
        u.mant    = u.is_zero ? '0 : {1'b1, f[MAN_W-1:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_sub_pipe_if.sv
// ----------------------------------------------------------------------------
// fp_sub_pipe_if
// Operand/result handshake bundle for fp_sub_pipe.
//   in_valid/in_ready   : operand pair transfer (flpA minuend, flpB subtrahend)
//   out_valid/out_ready : result transfer (flpout = flpA - flpB)
// slave  : the subtractor's view
// master : the producer/consumer (environment) view
// ----------------------------------------------------------------------------
interface fp_sub_pipe_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] flpA;
    logic [DW-1:0] flpB;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] flpout;

    modport slave (
        input  in_valid, flpA, flpB, out_ready,
        output in_ready, out_valid, flpout
    );

    modport master (
        output in_valid, flpA, flpB, out_ready,
        input  in_ready, out_valid, flpout
    );
endinterface

// File: rtl/fp_lzc.sv
// ----------------------------------------------------------------------------
// fp_lzc
// Combinational leading-zero counter for a 24-bit significand.
//   val_i   [23:0] : value to scan (bit 23 is the MSB)
//   count_o [4:0]  : number of leading zeros; 24 when val_i is all zero
// ----------------------------------------------------------------------------
module fp_lzc (
    input  logic [23:0] val_i,
    output logic [4:0]  count_o
);
    // NOTE: every variable driven from always_comb gets a default before any
    //       conditional update, so no path leaves it unassigned (no latch).
    always_comb begin
        count_o = 5'd24;
        // Scan upward; the highest set bit is the last one to write count_o.
        for (int i = 0; i < 24; i++) begin
            if (val_i[i]) count_o = 5'(23 - i);
        end
    end
endmodule

// File: rtl/fp_sub_pipe.sv
// ----------------------------------------------------------------------------
// fp_sub_pipe
// Three-stage pipelined single-precision subtractor, flpout = flpA - flpB.
// Truncating arithmetic, denormals flushed to zero, matching fp_add.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, discards all in-flight operations
//   bus  : fp_sub_pipe_if.slave (in_valid/in_ready/flpA/flpB,
//          out_valid/out_ready/flpout)
// One operation per cycle, fixed 3-cycle latency, results in order. The whole
// pipe stalls together while a result waits for out_ready.
// Build option: define FP_SUB_SPECIALS_EN to decode inf/NaN operands; without
// it exponent 255 is handled as an ordinary normalized number.
// ----------------------------------------------------------------------------
module fp_sub_pipe #(
    parameter  int EXP_W = fp_pkg::EXP_W,
    parameter  int MAN_W = fp_pkg::MAN_W,
    localparam int DW    = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    fp_sub_pipe_if.slave bus
);
    import fp_pkg::*;

    logic          adv;
    s1_reg_t       s1_q, s1_d;
    s2_reg_t       s2_q, s2_d;
    logic          out_valid_q;
    logic [DW-1:0] flpout_q, flpout_d;

    // The output register is the only place a result can wait, so every stage
    // moves exactly when it is empty or being drained.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.flpout    = flpout_q;

    // ---------------- S1: unpack, order by magnitude ----------------
    fp_unpacked_t ua, ub;
    logic         swap;

`ifdef FP_SUB_SPECIALS_EN
    logic a_max, b_max, a_nan, b_nan, a_inf, b_inf;
`endif

    always_comb begin
        ua = fp_unpack(bus.flpA, 1'b0);
        ub = fp_unpack(bus.flpB, 1'b1);
        // X takes B only when B is strictly larger; ties keep A's sign.
        swap = ua.is_zero || (!ub.is_zero && ({ub.exp, ub.mant} > {ua.exp, ua.mant}));

        s1_d         = '0;
        s1_d.valid   = bus.in_valid;
        s1_d.sign    = swap ? ub.sign : ua.sign;
        s1_d.exp     = swap ? ub.exp  : ua.exp;
        s1_d.mant_x  = swap ? ub.mant : ua.mant;
        s1_d.mant_y  = swap ? ua.mant : ub.mant;
        s1_d.diff    = swap ? (ub.exp - ua.exp) : (ua.exp - ub.exp);
        s1_d.eff_sub = (ua.sign != ub.sign);

`ifdef FP_SUB_SPECIALS_EN
        a_max = (bus.flpA[DW-2:MAN_W] == FP_INF_EXP);
        b_max = (bus.flpB[DW-2:MAN_W] == FP_INF_EXP);
        a_nan = a_max && (|bus.flpA[MAN_W-1:0]);
        b_nan = b_max && (|bus.flpB[MAN_W-1:0]);
        a_inf = a_max && !a_nan;
        b_inf = b_max && !b_nan;
        // inf - inf with equal raw signs is an effective subtraction of infinities.
        if (a_nan || b_nan || (a_inf && b_inf && (bus.flpA[DW-1] == bus.flpB[DW-1]))) begin
            s1_d.special     = 1'b1;
            s1_d.special_val = FP_QNAN;
        end else if (a_inf) begin
            s1_d.special     = 1'b1;
            s1_d.special_val = {bus.flpA[DW-1], FP_INF_EXP, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_d.special     = 1'b1;
            s1_d.special_val = {~bus.flpB[DW-1], FP_INF_EXP, {MAN_W{1'b0}}};
        end
`endif
    end

    // ---------------- S2: align and add/subtract ----------------
    logic [SIG_W-1:0] y_sh;

    always_comb begin
        // Bits shifted out of Y are dropped: no guard/round/sticky.
        y_sh = (s1_q.diff >= 8'd25) ? '0 : (s1_q.mant_y >> s1_q.diff);

        s2_d             = '0;
        s2_d.valid       = s1_q.valid;
        s2_d.sign        = s1_q.sign;
        s2_d.exp         = s1_q.exp;
        s2_d.special     = s1_q.special;
        s2_d.special_val = s1_q.special_val;
        // X >= Y by construction, so the difference never goes negative.
        s2_d.sum = s1_q.eff_sub ? ({1'b0, s1_q.mant_x} - {1'b0, y_sh})
                                : ({1'b0, s1_q.mant_x} + {1'b0, y_sh});
    end

    // ---------------- S3: normalize and pack ----------------
    logic [4:0]         lz;
    logic signed [9:0]  exp_n;
    logic [MAN_W-1:0]   frac_n;

    fp_lzc u_lzc (
        .val_i   (s2_q.sum[SIG_W-1:0]),
        .count_o (lz)
    );

    always_comb begin
        if (s2_q.sum[SUM_W-1]) begin
            frac_n = s2_q.sum[SIG_W-1:1];
            exp_n  = $signed({2'b00, s2_q.exp}) + 10'sd1;
        end else begin
            // The hidden bit shifts out of the top, leaving only the fraction.
            frac_n = MAN_W'(s2_q.sum[MAN_W-1:0] << lz);
            exp_n  = $signed({2'b00, s2_q.exp}) - $signed({5'b00000, lz});
        end

        flpout_d = FP_POS_ZERO;
        if (s2_q.special) begin
            flpout_d = s2_q.special_val;
        end else if (s2_q.sum == '0) begin
            flpout_d = FP_POS_ZERO;
        end else if (exp_n <= 10'sd0) begin
            flpout_d = FP_POS_ZERO;
        end else if (exp_n >= 10'sd255) begin
            flpout_d = {s2_q.sign, FP_INF_EXP, {MAN_W{1'b0}}};
        end else begin
            flpout_d = {s2_q.sign, exp_n[EXP_W-1:0], frac_n};
        end
    end

    // ---------------- stage registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every stage
    //       samples the previous stage's pre-edge value.
    // NOTE: data fields are reset along with the valids; flpout must read 0
    //       out of reset and these are flops, not a memory array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            flpout_q    <= '0;
        end else if (adv) begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= s2_q.valid;
            flpout_q    <= flpout_d;
        end
    end

endmodule

// File: tb/tb_fp_sub_pipe.sv
// ----------------------------------------------------------------------------
// tb_fp_sub_pipe
// Self-checking bench for fp_sub_pipe: directed operand pairs, expected
// results queued at accept time and compared when the DUT presents them.
// ----------------------------------------------------------------------------
module tb_fp_sub_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_sub_pipe_if #(.DW(32)) bus ();

    fp_sub_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total  = 0;
    int          passed = 0;
    int          n_in   = 0;
    int          n_out  = 0;
    logic [31:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    // Scoreboard: any presented result must match the oldest queued value,
    // every cycle it is held; it is retired only when actually transferred.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_out_valid", {31'b0, bus.out_valid}, 32'd0);
            end else begin
                check($sformatf("result%0d", n_out), bus.flpout, sb_q[0]);
                if (bus.out_ready) begin
                    void'(sb_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        bus.in_valid = 1'b1;
        bus.flpA     = a;
        bus.flpB     = b;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(expv);
                n_in++;
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.flpA      = '0;
        bus.flpB      = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_flpout",    bus.flpout,             32'd0);
        check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 3.0 - 1.0, with exact latency
        drive(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
        check("lat_edge1", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge2", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge3", {31'b0, bus.out_valid}, 32'd1);
        drain();

        // Directed arithmetic cases, back to back
        drive(32'h3F80_0000, 32'h3FC0_0000, 32'hBF00_0000); // 1.0 - 1.5
        drive(32'hBF80_0000, 32'hBF80_0000, 32'h0000_0000); // exact cancel
        drive(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000); // carry path
        drive(32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000); // diff >= 25
        drive(32'h4120_0000, 32'h3F80_0000, 32'h4110_0000); // 10 - 1
        drive(32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000); // 0 - B
        drive(32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000); // A - 0
        drive(32'h8000_0000, 32'h0000_0000, 32'h0000_0000); // -0 - 0
        drive(32'h0000_0001, 32'h0000_0002, 32'h0000_0000); // denormals flushed
        drive(32'h00C0_0000, 32'h0080_0000, 32'h0000_0000); // underflow flush
        drive(32'h7F00_0000, 32'hFF00_0000, 32'h7F80_0000); // overflow -> +inf
        drive(32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000); // finite - inf
`ifdef FP_SUB_SPECIALS_EN
        drive(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000); // inf - inf
        drive(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000); // NaN in
        drive(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000); // -inf - finite
`else
        drive(32'h7F80_0000, 32'h7F80_0000, 32'h0000_0000); // equal big numbers
        drive(32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0000); // saturates
        drive(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000); // saturates negative
`endif
        drain();

        // Six back-to-back ops with the consumer stalled for three cycles
        fork
            begin
                drive(32'h40A0_0000, 32'h4000_0000, 32'h4040_0000); // 5 - 2
                drive(32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000); // 1.5 - 1
                drive(32'h4000_0000, 32'hC000_0000, 32'h4080_0000); // 2 - (-2)
                drive(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000); // 3 - 1
                drive(32'h3F80_0000, 32'h3FC0_0000, 32'hBF00_0000); // 1 - 1.5
                drive(32'h4120_0000, 32'h3F80_0000, 32'h4110_0000); // 10 - 1
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
                check("stall_in_ready",  {31'b0, bus.in_ready},  32'd0);
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("emitted_count", 32'(n_out), 32'(n_in));

        // Async reset with three operations in flight
        drive(32'h40A0_0000, 32'h4000_0000, 32'h4040_0000);
        drive(32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000);
        drive(32'h4000_0000, 32'hC000_0000, 32'h4080_0000);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("async_rst_flpout",    bus.flpout,             32'd0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("no_stale%0d", c), {31'b0, bus.out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        drive(32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
